// File: rtl/shift_latch_rx_pkg.sv
// Shared constants for the clocked serial-latch link: FSM encoding and count width.
package shift_latch_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_LATCHED = 2'd2
  } state_e;

  // Bit counter must hold 0..WIDTH+1 (WIDTH+1 marks an overrun).
  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/shift_latch_rx_if.sv
// Link lines into the receiver and the parallel word it presents.
interface shift_latch_rx_if #(
  parameter int unsigned WIDTH = 16
);
  import shift_latch_rx_pkg::*;

  localparam int unsigned CW = count_width(WIDTH);

  logic             i_PSCLK;
  logic             i_SerData;
  logic             i_Latch;
  logic [WIDTH-1:0] o_Data;
  logic             o_Valid;
  logic             o_FrameErr;
  logic [CW-1:0]    o_BitCount;

  modport slave (
    input  i_PSCLK, i_SerData, i_Latch,
    output o_Data, o_Valid, o_FrameErr, o_BitCount
  );

  modport master (
    output i_PSCLK, i_SerData, i_Latch,
    input  o_Data, o_Valid, o_FrameErr, o_BitCount
  );

endinterface

// File: rtl/shift_latch_rx_sync_edge.sv
// Multi-stage synchroniser with registered rise/fall pulses; o_Sync is the level
// the pulses were derived from, so level and edges stay cycle-aligned.
module shift_latch_rx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_CLK,
  input  logic i_SYS_RESET,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_cur;

  assign w_cur = r_sync[SYNC_STAGES-1];

  // Synchroniser chain is left free-running so reset cannot fake an edge.
  always_ff @(posedge i_CLK) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_Async};
  end

  always_ff @(posedge i_CLK) begin
    if (i_SYS_RESET) begin
      r_prev <= w_cur;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_cur;
      r_rise <= w_cur & ~r_prev;
      r_fall <= ~w_cur & r_prev;
    end
  end

  assign o_Sync = r_prev;
  assign o_Rise = r_rise;
  assign o_Fall = r_fall;

endmodule

// File: rtl/shift_latch_rx.sv
// Receive end of the serial-latch link: deserialises one frame per latch strobe
// and publishes it only when exactly WIDTH bits arrived.
module shift_latch_rx
  import shift_latch_rx_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LSB_FIRST   = 1'b0
) (
  input logic             i_CLK,
  input logic             i_SYS_RESET,
  shift_latch_rx_if.slave bus
);

  localparam int unsigned   CW       = count_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

  logic w_sck_rise;
  logic w_dat;
  logic w_lat_lvl;
  logic w_lat_rise;
  logic w_lat_fall;
  logic w_unused_sck_sync;
  logic w_unused_sck_fall;
  logic w_unused_dat_rise;
  logic w_unused_dat_fall;

  shift_latch_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .i_CLK       (i_CLK),
    .i_SYS_RESET (i_SYS_RESET),
    .i_Async     (bus.i_PSCLK),
    .o_Sync      (w_unused_sck_sync),
    .o_Rise      (w_sck_rise),
    .o_Fall      (w_unused_sck_fall)
  );

  shift_latch_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat (
    .i_CLK       (i_CLK),
    .i_SYS_RESET (i_SYS_RESET),
    .i_Async     (bus.i_SerData),
    .o_Sync      (w_dat),
    .o_Rise      (w_unused_dat_rise),
    .o_Fall      (w_unused_dat_fall)
  );

  shift_latch_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lat (
    .i_CLK       (i_CLK),
    .i_SYS_RESET (i_SYS_RESET),
    .i_Async     (bus.i_Latch),
    .o_Sync      (w_lat_lvl),
    .o_Rise      (w_lat_rise),
    .o_Fall      (w_lat_fall)
  );

  state_e           r_state, w_state_n;
  logic [WIDTH-1:0] r_shreg, w_shreg_n;
  logic [WIDTH-1:0] r_data, w_data_n;
  logic [CW-1:0]    r_count, w_count_n;
  logic             r_valid, w_valid_n;
  logic             r_ferr, w_ferr_n;
  logic             w_take_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_shifted = LSB_FIRST ? {w_dat, r_shreg[WIDTH-1:1]}
                               : {r_shreg[WIDTH-2:0], w_dat};

  always_ff @(posedge i_CLK) begin
    if (i_SYS_RESET) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shreg <= w_shreg_n;
      r_data  <= w_data_n;
      r_count <= w_count_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
    end
  end

  // A bit arriving together with the latch edge is shifted first, then the frame closes.
  always_comb begin
    w_state_n  = r_state;
    w_shreg_n  = r_shreg;
    w_data_n   = r_data;
    w_count_n  = r_count;
    w_valid_n  = 1'b0;
    w_ferr_n   = 1'b0;
    w_take_bit = 1'b0;

    case (r_state)
      ST_IDLE:  w_take_bit = w_sck_rise && (!w_lat_lvl || w_lat_rise);
      ST_SHIFT: w_take_bit = w_sck_rise;
      default:  w_take_bit = 1'b0;
    endcase

    if (w_take_bit) begin
      w_shreg_n = w_shifted;
      w_count_n = (r_count == CNT_MAX) ? CNT_MAX : r_count + CW'(1);
      if (r_state == ST_IDLE) w_state_n = ST_SHIFT;
    end

    if (r_state != ST_LATCHED && w_lat_rise) begin
      if (w_count_n == CNT_FULL) begin
        w_data_n  = w_shreg_n;
        w_valid_n = 1'b1;
      end else begin
        w_ferr_n = 1'b1;
      end
      w_shreg_n = '0;
      w_count_n = '0;
      w_state_n = ST_LATCHED;
    end

    if (r_state == ST_LATCHED && w_lat_fall) w_state_n = ST_IDLE;
  end

  assign bus.o_Data     = r_data;
  assign bus.o_Valid    = r_valid;
  assign bus.o_FrameErr = r_ferr;
  assign bus.o_BitCount = r_count;

endmodule

// File: doc/shift_latch_rx.md
Name: shift_latch_rx

Overview:
- Receive end of the board's clocked serial-latch link: serial data, shift clock and latch strobe, as driven by the LED and 7-segment serializers.
- Samples all three link lines in the i_CLK domain, deserialises one frame and presents the word in parallel when the latch strobe rises.
- Used for FPGA-side loopback of the LED/7-seg drivers and for daisy-chained peripheral boards that speak the same link.

Parameters:
- WIDTH, 16, bits per frame; also the output word width.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
- LSB_FIRST, 0: 0 = first bit received lands in o_Data[WIDTH-1]; 1 = first bit lands in o_Data[0].

Ports:
- i_CLK  in  1  system clock; all logic is on the rising edge.
- i_SYS_RESET  in  1  synchronous reset, active-high.
- i_PSCLK  in  1  link shift clock, asynchronous to i_CLK; data is valid on its rising edge.
- i_SerData  in  1  link serial data.
- i_Latch  in  1  link latch strobe; a rising edge closes the frame.
- o_Data  out  WIDTH  last good frame; held between frames.
- o_Valid  out  1  one-cycle pulse when o_Data updates.
- o_FrameErr  out  1  one-cycle pulse when a frame closes with a bad bit count.
- o_BitCount  out  $clog2(WIDTH+2)  bits received in the current frame; saturates at WIDTH+1.

Behaviour:
- Interface: one clock, i_CLK. Reset i_SYS_RESET is synchronous and active-high.
- Synchronisers: i_PSCLK, i_SerData and i_Latch each pass through SYNC_STAGES flip-flops. One further register per line supplies the previous value for edge detection.
- Edge detect: sck_rise = synced PSCLK 0→1. lat_rise = synced Latch 0→1. lat_fall = synced Latch 1→0.
- Data sampling: data is sampled from the synchronised i_SerData in the same cycle as sck_rise. The link transmitter changes data on the PSCLK falling edge, so data is stable at the rise.
- Link-timing requirement: the link clock must be at most i_CLK/4 (5 MHz link against ≥20 MHz i_CLK). Each PSCLK high and low phase must last at least 2 i_CLK cycles.
- Reset state: FSM is IDLE; the shift register, o_Data and o_BitCount are 0; o_Valid and o_FrameErr are 0; the edge-history registers are loaded with the current synchronised values so that no edge is detected immediately after reset.
- FSM states: IDLE, SHIFT, LATCHED.
- IDLE: on sck_rise (with latch low), shift in one bit, set count to 1, go to SHIFT. On lat_rise with count 0, go to LATCHED and pulse o_FrameErr (empty frame).
- SHIFT: on each sck_rise, shift in one bit and increment count, saturating at WIDTH+1.
- Shift direction, LSB_FIRST=0: shreg <= {shreg[WIDTH-2:0], d}. LSB_FIRST=1: shreg <= {d, shreg[WIDTH-1:1]}.
- Closing a frame: on lat_rise, if count == WIDTH, then o_Data <= shreg and o_Valid pulses for 1 cycle. Otherwise o_Data is held and o_FrameErr pulses for 1 cycle. In both cases count is cleared and the FSM goes to LATCHED.
- Simultaneous sck_rise and lat_rise in one cycle: the bit is shifted in first and counted, then the frame is closed including that bit.
- LATCHED: sck_rise is ignored (no shift, no count). On lat_fall, go to IDLE.
- Latency: o_Valid and o_FrameErr assert exactly SYNC_STAGES+2 i_CLK cycles after i_Latch rises at the pin. o_Data changes in the same cycle as o_Valid.
- Overrun: more than WIDTH bits before the latch means count saturates at WIDTH+1 and the frame is reported as an error. Extra bits are never silently kept.
- Glitches: a PSCLK or Latch pulse shorter than 1 i_CLK cycle may be missed; this is not flagged. The resulting bad count is reported through o_FrameErr.
- Reset mid-frame: partial data is discarded and all outputs take their reset values on the next cycle. The next frame must start with a fresh bit 0.
- o_BitCount reflects the registered count; it is 0 in IDLE and LATCHED.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SHIFT=2'd1, LATCHED=2'd2) and the count width function clog2(WIDTH+2). The LED/7-seg transmitters use the same constants.
- One natural sub-module: sync_edge (SYNC_STAGES synchroniser plus rise/fall detect). It is instantiated three times; the data instance uses only the synced output.

Test Plan:
- Nominal frame, WIDTH=16, LSB_FIRST=0, i_CLK=20 MHz, PSCLK=5 MHz: shift 16'h5E8A MSB first, then raise the latch → o_Data=16'h5E8A, a single o_Valid pulse SYNC_STAGES+2 cycles after the latch edge, o_FrameErr=0.
- Short frame: 15 bits, then latch → o_FrameErr pulses, o_Data keeps its previous value (16'h5E8A), o_Valid=0. A following good frame of 16'h00FF updates o_Data.
- Overrun: 20 bits of 1, then latch → o_BitCount reads 17 just before the latch, o_FrameErr pulses, o_Data unchanged.
- PSCLK edges during latch-high: 4 clocks while the latch is high, then latch low, then a 16-bit frame of 16'h1234 → o_Data=16'h1234; the during-latch clocks are not counted.
- Simultaneous sck_rise and lat_rise on the 16th bit of 16'hFFFE (bit 0 arrives with the latch) → o_Data=16'hFFFE, o_Valid pulses.
- Reset mid-frame: 8 bits, assert i_SYS_RESET for 1 cycle, then a full frame of 16'hA5A5 → o_Data=16'hA5A5, no error. During and after reset o_Data=0 and o_BitCount=0 until the new frame. Repeat with LSB_FIRST=1 and confirm the bit order is reversed.
